// File: rtl/fft16_sequencer_if.sv
// Handshake and address bus between the FFT frame sequencer and its environment.
// master: the sequencer side; slave: the datapath/stream side driving the inputs.
interface fft16_sequencer_if;
    logic        i_start;
    logic        i_in_valid;
    logic        o_in_ready;
    logic        o_wr_en;
    logic [3:0]  o_wr_addr;
    logic        o_bfly_en;
    logic [1:0]  o_stage;
    logic [3:0]  o_rd_addr_a;
    logic [3:0]  o_rd_addr_b;
    logic [2:0]  o_tw_addr;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [3:0]  o_out_addr;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_frame_cnt;

    modport master (
        input  i_start, i_in_valid, i_out_ready,
        output o_in_ready, o_wr_en, o_wr_addr, o_bfly_en, o_stage, o_rd_addr_a,
               o_rd_addr_b, o_tw_addr, o_out_valid, o_out_addr, o_busy, o_frame_done,
               o_frame_cnt
    );

    modport slave (
        output i_start, i_in_valid, i_out_ready,
        input  o_in_ready, o_wr_en, o_wr_addr, o_bfly_en, o_stage, o_rd_addr_a,
               o_rd_addr_b, o_tw_addr, o_out_valid, o_out_addr, o_busy, o_frame_done,
               o_frame_cnt
    );
endinterface

// File: rtl/fft16_sequencer.sv
// Frame sequencer for the 16-point radix-2 FFT: bit-reversed load, 4 stages of 8
// butterflies with a BFLY_LAT-cycle flush after each stage, natural-order unload.
// Optional: define FFT_SEQ_FRAME_CNT_EN to build the completed-frame counter;
// otherwise o_frame_cnt is tied to zero.
module fft16_sequencer #(
    parameter int unsigned STAGES   = 4,
    parameter int unsigned BFLY_LAT = 2
) (
    input logic               i_clk,
    input logic               i_rst,
    fft16_sequencer_if.master bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StCompute, StFlush, StUnload} state_e;

    localparam logic [1:0] LastStage = 2'(STAGES - 1);
    localparam logic [2:0] LastFlush = 3'(BFLY_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;      // sample index n in LOAD, result index m in UNLOAD
    logic [2:0] k_q, k_d;          // butterfly index within a stage
    logic [1:0] s_q, s_d;          // stage
    logic [2:0] flush_q, flush_d;
    logic       done_q, done_d;

    logic       in_beat, out_beat, in_stage;
    logic [3:0] k_ext, pos, grp, addr_a, addr_b, span;
    logic [2:0] tw;

    assign in_beat  = (state_q == StLoad) && bus.i_in_valid;
    assign out_beat = (state_q == StUnload) && bus.i_out_ready;
    assign in_stage = (state_q == StCompute) || (state_q == StFlush);

    // State and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            s_q     <= '0;
            flush_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            s_q     <= s_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        s_d     = s_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (in_beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = StCompute;
                        s_d     = '0;
                        k_d     = '0;
                    end
                end
            end
            StCompute: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = StFlush;
                    flush_d = '0;
                end
            end
            StFlush: begin
                flush_d = flush_q + 3'd1;
                if (flush_q == LastFlush) begin
                    if (s_q == LastStage) begin
                        state_d = StUnload;
                        cnt_d   = '0;
                    end else begin
                        state_d = StCompute;
                        s_d     = s_q + 2'd1;
                        k_d     = '0;
                    end
                end
            end
            StUnload: begin
                if (out_beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Butterfly addressing: pos = k mod 2^s, grp = k >> s, a = grp*2^(s+1) + pos
    always_comb begin
        k_ext  = {1'b0, k_q};
        span   = 4'd1 << s_q;
        pos    = k_ext & (span - 4'd1);
        grp    = k_ext >> s_q;
        addr_a = (grp << (3'(s_q) + 3'd1)) | pos;
        addr_b = addr_a + span;
        tw     = 3'(pos[2:0] << (2'd3 - s_q));
    end

    assign bus.o_in_ready   = (state_q == StLoad);
    assign bus.o_wr_en      = in_beat;
    assign bus.o_wr_addr    = in_beat ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]} : 4'd0;
    assign bus.o_bfly_en    = (state_q == StCompute);
    assign bus.o_stage      = in_stage ? s_q : 2'd0;
    assign bus.o_rd_addr_a  = (state_q == StCompute) ? addr_a : 4'd0;
    assign bus.o_rd_addr_b  = (state_q == StCompute) ? addr_b : 4'd0;
    assign bus.o_tw_addr    = (state_q == StCompute) ? tw : 3'd0;
    assign bus.o_out_valid  = (state_q == StUnload);
    assign bus.o_out_addr   = (state_q == StUnload) ? cnt_q : 4'd0;
    assign bus.o_busy       = (state_q != StIdle);
    assign bus.o_frame_done = done_q;

`ifdef FFT_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter; updates on the same edge that raises o_frame_done
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
        end else if (done_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.o_frame_cnt = frame_cnt_q;
`else
    assign bus.o_frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fft16_sequencer.sv
// Scoreboard bench for fft16_sequencer: expected load, butterfly and unload
// addresses are queued per frame and popped as the DUT strobes them.
module tb_fft16_sequencer;
    localparam int unsigned BFLY_LAT = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [3:0]  wr_q[$];
    logic [12:0] bfly_q[$];   // {stage, a, b, tw}
    logic [3:0]  out_q[$];

    int unsigned gap = 0;
    int unsigned bfly_seen = 0;
    int unsigned done_seen = 0;
    int unsigned frames = 0;

    fft16_sequencer_if bus ();

    fft16_sequencer #(
        .STAGES  (4),
        .BFLY_LAT(BFLY_LAT)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned f);
`ifdef FFT_SEQ_FRAME_CNT_EN
        return 32'(f);
`else
        return 32'(f * 0);
`endif
    endfunction

    task automatic push_frame();
        for (int n = 0; n < 16; n++) begin
            logic [3:0] v;
            v = 4'(n);
            wr_q.push_back({v[0], v[1], v[2], v[3]});
        end
        for (int s = 0; s < 4; s++) begin
            int span;
            span = 1 << s;
            for (int g = 0; g < 8 / span; g++) begin
                for (int j = 0; j < span; j++) begin
                    int a;
                    a = g * 2 * span + j;
                    bfly_q.push_back({2'(s), 4'(a), 4'(a + span), 3'(j * (8 / span))});
                end
            end
        end
        for (int m = 0; m < 16; m++) out_q.push_back(4'(m));
        bfly_seen = 0;
        gap = 0;
    endtask

    // Monitor: pop expectations whenever the DUT strobes an address
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (bus.o_wr_en) begin
                check_eq("wr_pending", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) check_eq("wr_addr", 32'(bus.o_wr_addr), 32'(wr_q.pop_front()));
            end
            if (bus.o_bfly_en) begin
                if (bfly_seen != 0 && bfly_seen % 8 == 0) check_eq("flush_gap", gap, BFLY_LAT);
                gap = 0;
                bfly_seen++;
                check_eq("bfly_pending", 32'(bfly_q.size() != 0), 1);
                if (bfly_q.size() != 0)
                    check_eq("bfly_op", 32'({bus.o_stage, bus.o_rd_addr_a, bus.o_rd_addr_b,
                                             bus.o_tw_addr}), 32'(bfly_q.pop_front()));
            end else begin
                gap++;
            end
            if (bus.o_out_valid) begin
                check_eq("out_pending", 32'(out_q.size() != 0), 1);
                if (out_q.size() != 0) begin
                    check_eq("out_addr", 32'(bus.o_out_addr), 32'(out_q[0]));
                    if (bus.i_out_ready) void'(out_q.pop_front());
                end
            end
            if (bus.o_frame_done) done_seen++;
        end
    end

    task automatic run_frame(input bit stall, input bit disturb);
        int unsigned c0, c1, cd;
        bit ok;
        push_frame();
        bus.i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start    = 1'b1;
        bus.i_in_valid = 1'b1;
        c0 = cyc;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        check_eq("start_in_ready", 32'(bus.o_in_ready), 1);
        check_eq("start_busy", 32'(bus.o_busy), 1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge i_clk);
            if (bus.o_bfly_en) ok = 1'b1;
        end
        check_eq("bfly_start_seen", 32'(ok), 1);
        check_eq("load_ready_low", 32'(bus.o_in_ready), 0);
        check_eq("load_wr_left", wr_q.size(), 0);
        c1 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge i_clk);
            if (bus.o_out_valid) ok = 1'b1;
        end
        check_eq("unload_seen", 32'(ok), 1);
        check_eq("compute_cycles", cyc - c1, 4 * (8 + BFLY_LAT));
        check_eq("bfly_left", bfly_q.size(), 0);
        bus.i_in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge i_clk); #1;
            if (bus.o_frame_done) begin
                ok = 1'b1;
            end else begin
                bus.i_out_ready = stall ? !bus.i_out_ready : 1'b1;
                bus.i_start     = disturb && (i < 6);
                bus.i_in_valid  = disturb && (i < 6);
            end
        end
        bus.i_start    = 1'b0;
        bus.i_in_valid = 1'b0;
        cd = cyc;
        frames++;
        check_eq("frame_done_seen", 32'(ok), 1);
        check_eq("frame_latency", cd - c0, 1 + 16 + 4 * (8 + BFLY_LAT) + (stall ? 31 : 16));
        check_eq("out_left", out_q.size(), 0);
        check_eq("done_busy", 32'(bus.o_busy), 0);
        check_eq("frame_cnt", 32'(bus.o_frame_cnt), exp_cnt(frames));
        @(posedge i_clk); #1;
        check_eq("done_one_cycle", 32'(bus.o_frame_done), 0);
        if (disturb) begin
            repeat (3) begin
                @(negedge i_clk);
                check_eq("no_restart", 32'(bus.o_busy), 0);
            end
        end
    endtask

    initial begin
        bit ok;
        i_rst           = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b0;

        @(negedge i_clk);
        check_eq("rst_strobes", 32'({bus.o_in_ready, bus.o_wr_en, bus.o_bfly_en,
                                     bus.o_out_valid, bus.o_busy, bus.o_frame_done}), 0);
        check_eq("rst_addrs", 32'({bus.o_wr_addr, bus.o_stage, bus.o_rd_addr_a,
                                   bus.o_rd_addr_b, bus.o_tw_addr, bus.o_out_addr}), 0);
        check_eq("rst_frame_cnt", 32'(bus.o_frame_cnt), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_eq("idle_busy", 32'(bus.o_busy), 0);

        // Stalled unload with start/valid noise during UNLOAD
        run_frame(1'b1, 1'b1);
        // Back-to-back frame with identical address sequences
        run_frame(1'b0, 1'b0);
        check_eq("done_count_2", done_seen, 2);

        // Reset abandoned in the middle of stage 2
        push_frame();
        bus.i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start    = 1'b1;
        bus.i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge i_clk);
            if (bus.o_bfly_en && bus.o_stage == 2'd2) ok = 1'b1;
        end
        check_eq("stage2_seen", 32'(ok), 1);
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("midrst_strobes", 32'({bus.o_in_ready, bus.o_wr_en, bus.o_bfly_en,
                                        bus.o_out_valid, bus.o_busy, bus.o_frame_done}), 0);
        check_eq("midrst_addrs", 32'({bus.o_wr_addr, bus.o_stage, bus.o_rd_addr_a,
                                      bus.o_rd_addr_b, bus.o_tw_addr, bus.o_out_addr}), 0);
        check_eq("midrst_frame_cnt", 32'(bus.o_frame_cnt), 0);
        wr_q.delete();
        bfly_q.delete();
        out_q.delete();
        bus.i_in_valid = 1'b0;
        frames = 0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            check_eq("post_rst_idle", 32'({bus.o_busy, bus.o_frame_done}), 0);
        end
        check_eq("done_count_rst", done_seen, 2);

        // Recovery frame after the abandoned one
        run_frame(1'b0, 1'b0);
        check_eq("done_count_3", done_seen, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft16_sequencer.md
# fft16_sequencer

Frame-level sequencer for the 16-point radix-2 FFT datapath. It accepts 16 input samples over a valid/ready handshake, writes them to the sample RAM in bit-reversed order, and then issues the 4×8 butterfly operations with per-stage read addresses, twiddle address and stage select. It inserts a pipeline flush between stages and then streams the 16 results out in natural order. It sits above the per-stage mux/control logic and owns all addressing of the sample RAM.

## Interface
- STAGES, 4, log2 of point count; fixed at 4 for the 16-point core
- BFLY_LAT, 2, butterfly read-to-writeback latency in cycles, range 1..7
- i_clk  in  1  clock, rising-edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin a frame; sampled only in IDLE
- i_in_valid  in  1  input sample present
- o_in_ready  out  1  sequencer accepts a sample (LOAD state)
- o_wr_en  out  1  sample-RAM write strobe for the load path (= i_in_valid & o_in_ready)
- o_wr_addr  out  4  bit-reversed load address
- o_bfly_en  out  1  butterfly issue strobe
- o_stage  out  2  current stage s, drives the datapath mux select
- o_rd_addr_a  out  4  butterfly top operand address
- o_rd_addr_b  out  4  butterfly bottom operand address (a + 2^s)
- o_tw_addr  out  3  twiddle ROM index
- o_out_valid  out  1  result address valid (UNLOAD state)
- i_out_ready  in  1  downstream accepts result
- o_out_addr  out  4  natural-order unload address
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse after the last unload beat
- o_frame_cnt  out  16  completed-frame count (see Configuration)

## Operation
- States: IDLE → LOAD → COMPUTE ⇄ FLUSH → UNLOAD → IDLE.
- IDLE: all strobes low. i_start=1 → LOAD next cycle.
- LOAD: o_in_ready=1. On each i_in_valid&o_in_ready beat, sample counter n (4 bits) increments; o_wr_addr = bitrev(n). Beat at n=15 → COMPUTE, with s=0 and k=0.
- COMPUTE: o_bfly_en=1 every cycle; k = 0..7. With span=2^s, pos=k mod span, grp=k>>s: a=(grp<<(s+1))|pos, b=a+span, tw=pos<<(3−s). At k=7 → FLUSH.
- FLUSH: o_bfly_en=0 for BFLY_LAT cycles. Then, if s<3: s++, k=0, → COMPUTE. If s=3: → UNLOAD.
- UNLOAD: o_out_valid=1, o_out_addr=m (0..15). m advances only on o_out_valid&i_out_ready; address is held stable while stalled. Beat at m=15 → IDLE and o_frame_done=1 for one cycle.
- i_start outside IDLE: ignored. i_in_valid outside LOAD: ignored, no write.
- All counter widths wrap naturally. No counter passes its terminal value because state transitions occur at terminal count.

## Timing
- Reset (async, immediate) values: state=IDLE, all counters 0, every output 0 (o_in_ready, o_wr_en, o_bfly_en, o_out_valid, o_busy, o_frame_done, o_frame_cnt = 0; all addresses and o_stage = 0).
- Outputs are decoded from registered state/counters. The exceptions are o_wr_en and o_wr_addr, which follow the current-cycle handshake.
- i_start high at edge t → o_in_ready and o_busy high from t+1.
- COMPUTE+FLUSH duration is exactly 4·(8+BFLY_LAT) cycles (40 at default).
- Minimum frame with no stalls: 1 + 16 + 40 + 16 cycles from i_start to o_frame_done.
- Reset mid-frame: the frame is abandoned, the sequencer returns to IDLE, no o_frame_done is produced, and o_frame_cnt is cleared.

## Configuration
- FFT_SEQ_FRAME_CNT_EN defined: o_frame_cnt is a 16-bit register that increments, wrapping 0xFFFF→0, in the same cycle o_frame_done pulses.
- Not defined: no counter register is built, and o_frame_cnt is tied to 0.

## Test plan
- Reset then idle: outputs all 0. A single i_start pulse gives o_in_ready=1 on the next cycle and o_busy=1.
- Load 16 beats with i_in_valid stuck at 1: the o_wr_addr sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. Then o_in_ready drops.
- Compute order at BFLY_LAT=2:
  - stage 0 (a,b) = (0,1),(2,3)…(14,15), tw all 0;
  - stage 3 (a,b) = (0,8)…(7,15), tw = 0..7;
  - exactly 2 idle o_bfly_en cycles between stages;
  - 40 cycles total.
- Unload with i_out_ready toggling 1,0,1,0: o_out_addr holds during stalls and covers 0..15 once. o_frame_done pulses once and o_frame_cnt=1 (macro defined) or 0 (undefined).
- Assert i_rst during COMPUTE stage 2: all outputs 0 immediately and state is IDLE. i_start and i_in_valid during UNLOAD are ignored (no writes, no restart).
- Two back-to-back frames: o_frame_cnt=2, and the second frame's address sequences are identical to the first.
